// File: rtl/rate_limit_cfg_seq_pkg.sv
// Shared encodings and ring widths for the rate limiter configuration sequencer.
// Ring width macros fall back to board defaults when the build does not provide them.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif
`ifndef RATE_LIMIT_REG_ADDR_WIDTH
`define RATE_LIMIT_REG_ADDR_WIDTH 6
`endif
`ifndef RATE_LIMIT_0_BLOCK_ADDR
`define RATE_LIMIT_0_BLOCK_ADDR 17'h00040
`endif

package rate_limit_cfg_seq_pkg;

   localparam int REG_ADDR_W = `UDP_REG_ADDR_WIDTH;
   localparam int REG_DATA_W = `CPCI_NF2_DATA_WIDTH;
   localparam int RL_REG_W   = `RATE_LIMIT_REG_ADDR_WIDTH;
   localparam int RL_TAG_W   = REG_ADDR_W - RL_REG_W;

   // Register indices inside a rate limiter block, shared with its register file.
   localparam logic [RL_REG_W-1:0] RATE_LIMIT_ENABLE = RL_REG_W'(0);
   localparam logic [RL_REG_W-1:0] RATE_LIMIT_SHIFT  = RL_REG_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2,
      ST_DONE  = 2'd3
   } cfg_state_t;

   typedef enum logic [1:0] {
      STEP_DISABLE = 2'd0,
      STEP_SHIFT   = 2'd1,
      STEP_ENABLE  = 2'd2
   } cfg_step_t;

   function automatic logic [RL_REG_W-1:0] step_reg_idx(input cfg_step_t step);
      return (step == STEP_SHIFT) ? RATE_LIMIT_SHIFT : RATE_LIMIT_ENABLE;
   endfunction

endpackage

// File: rtl/rate_limit_cfg_ring_mux.sv
// Registered ring output stage: forwards ring inputs or an injected write, one cycle later.
// Owns the reset values of every ring output.
module rate_limit_cfg_ring_mux
   import rate_limit_cfg_seq_pkg::*;
#(
   parameter int SRC_W = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  inject,
   input  logic [REG_ADDR_W-1:0] inj_addr,
   input  logic [REG_DATA_W-1:0] inj_data,
   input  logic [SRC_W-1:0]      inj_src,
   input  logic                  reg_req_in,
   input  logic                  reg_ack_in,
   input  logic                  reg_rd_wr_L_in,
   input  logic [REG_ADDR_W-1:0] reg_addr_in,
   input  logic [REG_DATA_W-1:0] reg_data_in,
   input  logic [SRC_W-1:0]      reg_src_in,
   output logic                  reg_req_out,
   output logic                  reg_ack_out,
   output logic                  reg_rd_wr_L_out,
   output logic [REG_ADDR_W-1:0] reg_addr_out,
   output logic [REG_DATA_W-1:0] reg_data_out,
   output logic [SRC_W-1:0]      reg_src_out
);

   logic                  req_d, req_q;
   logic                  ack_d, ack_q;
   logic                  rd_wr_L_d, rd_wr_L_q;
   logic [REG_ADDR_W-1:0] addr_d, addr_q;
   logic [REG_DATA_W-1:0] data_d, data_q;
   logic [SRC_W-1:0]      src_d, src_q;

   // Injection only happens in idle slots, so the dropped inputs carry no request.
   always_comb begin
      if (inject) begin
         req_d     = 1'b1;
         ack_d     = 1'b0;
         rd_wr_L_d = 1'b0;
         addr_d    = inj_addr;
         data_d    = inj_data;
         src_d     = inj_src;
      end else begin
         req_d     = reg_req_in;
         ack_d     = reg_ack_in;
         rd_wr_L_d = reg_rd_wr_L_in;
         addr_d    = reg_addr_in;
         data_d    = reg_data_in;
         src_d     = reg_src_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_q     <= 1'b0;
         ack_q     <= 1'b0;
         rd_wr_L_q <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         src_q     <= '0;
      end else begin
         req_q     <= req_d;
         ack_q     <= ack_d;
         rd_wr_L_q <= rd_wr_L_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         src_q     <= src_d;
      end
   end

   assign reg_req_out     = req_q;
   assign reg_ack_out     = ack_q;
   assign reg_rd_wr_L_out = rd_wr_L_q;
   assign reg_addr_out    = addr_q;
   assign reg_data_out    = data_q;
   assign reg_src_out     = src_q;

endmodule

// File: rtl/rate_limit_cfg_seq.sv
// Rate limiter configuration sequencer: injects disable/shift/enable writes per limiter.
// Optional RATE_LIMIT_CFG_AUTO_START_EN runs one sequence right after reset release.
module rate_limit_cfg_seq
   import rate_limit_cfg_seq_pkg::*;
#(
   parameter int                         UDP_REG_SRC_WIDTH = 2,
   parameter int                         NUM_LIMITERS      = 4,
   parameter logic [RL_TAG_W-1:0]        BASE_BLOCK_TAG    = RL_TAG_W'(`RATE_LIMIT_0_BLOCK_ADDR),
   parameter logic [UDP_REG_SRC_WIDTH-1:0] SRC_ID          = UDP_REG_SRC_WIDTH'(2'b11),
   parameter int                         GAP_CYCLES        = 3
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         reg_req_in,
   input  logic                         reg_ack_in,
   input  logic                         reg_rd_wr_L_in,
   input  logic [REG_ADDR_W-1:0]        reg_addr_in,
   input  logic [REG_DATA_W-1:0]        reg_data_in,
   input  logic [UDP_REG_SRC_WIDTH-1:0] reg_src_in,
   output logic                         reg_req_out,
   output logic                         reg_ack_out,
   output logic                         reg_rd_wr_L_out,
   output logic [REG_ADDR_W-1:0]        reg_addr_out,
   output logic [REG_DATA_W-1:0]        reg_data_out,
   output logic [UDP_REG_SRC_WIDTH-1:0] reg_src_out,
   input  logic                         cfg_start,
   input  logic [NUM_LIMITERS-1:0]      cfg_enable,
   input  logic [4*NUM_LIMITERS-1:0]    cfg_shift,
   output logic                         cfg_busy,
   output logic                         cfg_done,
   output cfg_state_t                   dbg_state
);

   localparam logic [3:0] LAST_LIM = 4'(NUM_LIMITERS - 1);

   cfg_state_t            state_q, state_d;
   cfg_step_t             step_q, step_d;
   logic [3:0]            lim_q, lim_d;
   logic [7:0]            gap_q, gap_d;
   logic [15:0]           en_q, en_d;
   logic [63:0]           shift_q, shift_d;
   logic                  start, adv, last_write, inject;
   logic [RL_TAG_W-1:0]   inj_tag;
   logic [REG_ADDR_W-1:0] inj_addr;
   logic [REG_DATA_W-1:0] inj_data;

`ifdef RATE_LIMIT_CFG_AUTO_START_EN
   logic auto_start_d, auto_start_q;
   assign auto_start_d = 1'b0;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) auto_start_q <= 1'b1;
      else       auto_start_q <= auto_start_d;
   end
   assign start = cfg_start | auto_start_q;
`else
   assign start = cfg_start;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         step_q  <= STEP_DISABLE;
         lim_q   <= '0;
         gap_q   <= '0;
         en_q    <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         lim_q   <= lim_d;
         gap_q   <= gap_d;
         en_q    <= en_d;
         shift_q <= shift_d;
      end
   end

   // GAP holds for GAP_CYCLES cycles, so each write costs 1+GAP_CYCLES cycles on an idle ring.
   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      lim_d      = lim_q;
      gap_d      = gap_q;
      en_d       = en_q;
      shift_d    = shift_q;
      adv        = 1'b0;
      last_write = (step_q == STEP_ENABLE) && (lim_q == LAST_LIM);
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               en_d    = 16'(cfg_enable);
               shift_d = 64'(cfg_shift);
               lim_d   = '0;
               step_d  = STEP_DISABLE;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (!reg_req_in) begin
               if (GAP_CYCLES == 0) begin
                  adv = 1'b1;
               end else begin
                  gap_d   = 8'(GAP_CYCLES);
                  state_d = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (gap_q <= 8'd1) adv = 1'b1;
            else               gap_d = gap_q - 8'd1;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (adv) begin
         if (last_write) begin
            state_d = ST_DONE;
         end else begin
            state_d = ST_ISSUE;
            if (step_q == STEP_ENABLE) begin
               step_d = STEP_DISABLE;
               lim_d  = lim_q + 4'd1;
            end else begin
               step_d = cfg_step_t'(step_q + 2'd1);
            end
         end
      end
   end

   always_comb begin
      inject   = (state_q == ST_ISSUE) && !reg_req_in;
      cfg_busy = (state_q == ST_ISSUE) || (state_q == ST_GAP);
      cfg_done = (state_q == ST_DONE);
      inj_tag  = BASE_BLOCK_TAG + RL_TAG_W'(lim_q);
      case (step_q)
         STEP_SHIFT:  inj_data = REG_DATA_W'(shift_q[{lim_q, 2'b00} +: 4]);
         STEP_ENABLE: inj_data = REG_DATA_W'(en_q[lim_q]);
         default:     inj_data = '0;
      endcase
      inj_addr = {inj_tag, step_reg_idx(step_q)};
   end

   assign dbg_state = state_q;

   rate_limit_cfg_ring_mux #(
      .SRC_W (UDP_REG_SRC_WIDTH)
   ) u_ring_mux (
      .clk             (clk),
      .reset           (reset),
      .inject          (inject),
      .inj_addr        (inj_addr),
      .inj_data        (inj_data),
      .inj_src         (SRC_ID),
      .reg_req_in      (reg_req_in),
      .reg_ack_in      (reg_ack_in),
      .reg_rd_wr_L_in  (reg_rd_wr_L_in),
      .reg_addr_in     (reg_addr_in),
      .reg_data_in     (reg_data_in),
      .reg_src_in      (reg_src_in),
      .reg_req_out     (reg_req_out),
      .reg_ack_out     (reg_ack_out),
      .reg_rd_wr_L_out (reg_rd_wr_L_out),
      .reg_addr_out    (reg_addr_out),
      .reg_data_out    (reg_data_out),
      .reg_src_out     (reg_src_out)
   );

endmodule
